// File: rtl/rr_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n_if
//   Request/grant bundle between N request sources and the round-robin
//   arbiter guarding a single shared resource.
//
//   Signals:
//     req         N    request vector, bit i = requester i wants the resource
//     grant       N    registered one-hot (or zero) grant vector
//     grant_id    IDW  index of the granted requester, 0 when nothing granted
//     grant_valid 1    OR of grant
//
//   Modports:
//     master  request side (drives req, observes the grant)
//     slave   arbiter side (observes req, drives the grant)
// ---------------------------------------------------------------------------
interface rr_arbiter_n_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output grant_valid
    );
endinterface : rr_arbiter_n_if

// File: rtl/rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n
//   N-way round-robin arbiter with a bounded grant hold. A requester keeps
//   the grant while it keeps requesting; under contention it is released
//   after MAX_HOLD consecutive cycles (MAX_HOLD = 0 means never forced off).
//   The next winner is found by searching from a rotating pointer that
//   always sits one past the most recent winner. All outputs are registered.
//
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-high reset
//     arb    rr_arbiter_n_if.slave: req in; grant, grant_id, grant_valid out
//
//   The interface instance must be built with the same N as this module.
// ---------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic          clock,
    input  logic          reset,
    rr_arbiter_n_if.slave arb
);
    localparam int IDW = $clog2(N);
    // Hold counter stores (cycles granted - 1), so it only needs to reach MAX_HOLD-1.
    localparam int CW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = (MAX_HOLD > 1) ? CW'(MAX_HOLD - 1) : '0;
    // With unlimited hold the counter is only informational; let it stick at all-ones.
    localparam logic [CW-1:0] CNT_SAT  = (MAX_HOLD == 0) ? '1 : CNT_LAST;

    // Registered state
    logic [N-1:0]   grant_q,       grant_d;
    logic [IDW-1:0] grant_id_q,    grant_id_d;
    logic           grant_valid_q, grant_valid_d;
    logic [IDW-1:0] ptr_q,         ptr_d;
    logic [CW-1:0]  cnt_q,         cnt_d;

    // Arbitration helpers
    logic           holder_req;
    logic           others_req;
    logic           hold_ok;
    logic           keep;
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW:0]   cand;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        found         = 1'b0;
        winner        = '0;
        cand          = '0;

        holder_req = |(arb.req & grant_q);
        others_req = |(arb.req & ~grant_q);
        hold_ok    = (MAX_HOLD == 0) || (cnt_q < CNT_LAST);
        keep       = grant_valid_q && holder_req && (hold_ok || !others_req);

        // Rotating search: index ptr, ptr+1, ... wrapped mod N; first hit wins.
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(N)) begin
                cand = cand - (IDW + 1)'(N);
            end
            if (!found && arb.req[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end

        if (keep) begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (found) begin
            grant_d       = {{(N - 1){1'b0}}, 1'b1} << winner;
            grant_id_d    = winner;
            grant_valid_d = 1'b1;
            cnt_d         = '0;
            // Pointer moves one past the winner, so the winner is searched last next time.
            ptr_d         = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
        end else begin
            grant_d       = '0;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
            cnt_d         = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous and overrides any request.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= '0;
            cnt_q         <= '0;
        end else begin
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_id    = grant_id_q;
    assign arb.grant_valid = grant_valid_q;

endmodule : rr_arbiter_n

// File: tb/tb_rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_n
//   Drives two 4-way arbiters from one clock/reset: dut_a with MAX_HOLD=4
//   and dut_b with MAX_HOLD=0 (unlimited hold). A reference model tracks the
//   current holder, the search start and the number of cycles held, and
//   every cycle the outputs of both instances are compared against it along
//   with the structural invariants. Directed vectors add literal expectations.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_n;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    bit   started;
    bit   done;

    rr_arbiter_n_if #(.N(N)) if_a ();
    rr_arbiter_n_if #(.N(N)) if_b ();

    rr_arbiter_n #(.N(N), .MAX_HOLD(4)) dut_a (
        .clock (clk),
        .reset (rst),
        .arb   (if_a)
    );

    rr_arbiter_n #(.N(N), .MAX_HOLD(0)) dut_b (
        .clock (clk),
        .reset (rst),
        .arb   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: holder (-1 = none), next search start, cycles held.
    // ------------------------------------------------------------------
    typedef struct {
        int holder;
        int ptr;
        int held;
    } mstate_t;

    function automatic mstate_t model_next(mstate_t s, logic [N-1:0] r, int max_hold);
        mstate_t n;
        bit      others;
        n      = s;
        others = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r[i] && i != s.holder) others = 1'b1;
        end
        if (s.holder >= 0 && r[s.holder] &&
            (max_hold == 0 || s.held < max_hold || !others)) begin
            if (s.held < 1000) n.held = s.held + 1;
        end else begin
            n.holder = -1;
            n.held   = 0;
            for (int k = 0; k < N; k++) begin
                if (n.holder < 0 && r[(s.ptr + k) % N]) begin
                    n.holder = (s.ptr + k) % N;
                    n.held   = 1;
                    n.ptr    = (n.holder + 1) % N;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [N-1:0] onehot_of(int holder);
        logic [N-1:0] g;
        g = '0;
        if (holder >= 0) g[holder] = 1'b1;
        return g;
    endfunction

    function automatic logic [1:0] idx_of(logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    mstate_t      sa;
    mstate_t      sb;
    logic [N-1:0] prev_req_a;
    logic [N-1:0] prev_req_b;

    always @(posedge clk) begin
        started    <= 1'b1;
        prev_req_a <= if_a.req;
        prev_req_b <= if_b.req;
        if (rst) begin
            sa <= '{holder: -1, ptr: 0, held: 0};
            sb <= '{holder: -1, ptr: 0, held: 0};
        end else begin
            sa <= model_next(sa, if_a.req, 4);
            sb <= model_next(sb, if_b.req, 0);
        end
    end

    task automatic cmp_dut(input string tag, input logic [N-1:0] g, input logic [1:0] id,
                           input logic v, input mstate_t s, input logic [N-1:0] pr);
        check({tag, "_mdl_grant"}, 32'(g), 32'(onehot_of(s.holder)));
        check({tag, "_mdl_id"}, 32'(id), (s.holder >= 0) ? 32'(s.holder) : 32'd0);
        check({tag, "_mdl_valid"}, 32'(v), 32'(s.holder >= 0));
        check({tag, "_inv_onehot"}, 32'($onehot0(g)), 32'd1);
        check({tag, "_inv_valid_or"}, 32'(v), 32'(|g));
        check({tag, "_inv_id_bit"}, v ? 32'(g[id]) : 32'd1, 32'd1);
        check({tag, "_inv_req_before"}, 32'(g & ~pr), 32'd0);
    endtask

    // One compare process for both instances, sampling away from the active edge.
    always @(negedge clk) begin
        if (started && !done) begin
            cmp_dut("a", if_a.grant, if_a.grant_id, if_a.grant_valid, sa, prev_req_a);
            cmp_dut("b", if_b.grant, if_b.grant_id, if_b.grant_valid, sb, prev_req_b);
        end
    end

    // ------------------------------------------------------------------
    // Directed vectors: drive for one edge, then check the literal grant
    // visible in the following cycle, repeated reps times.
    // ------------------------------------------------------------------
    task automatic run(input logic rs, input logic [N-1:0] ra, input logic [N-1:0] rb,
                       input int reps, input logic [N-1:0] ea, input logic [N-1:0] eb,
                       input string name);
        for (int i = 0; i < reps; i++) begin
            rst      = rs;
            if_a.req = ra;
            if_b.req = rb;
            @(posedge clk);
            @(negedge clk);
            check({name, "_a_grant"}, 32'(if_a.grant), 32'(ea));
            check({name, "_a_id"}, 32'(if_a.grant_id), 32'(idx_of(ea)));
            check({name, "_a_valid"}, 32'(if_a.grant_valid), 32'(|ea));
            check({name, "_b_grant"}, 32'(if_b.grant), 32'(eb));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        started  = 1'b0;
        done     = 1'b0;
        rst      = 1'b1;
        if_a.req = '0;
        if_b.req = '0;

        // Reset dominates a pending request.
        run(1'b1, 4'b0001, 4'b0001, 2, 4'b0000, 4'b0000, "reset");
        // Single requester 0, then release.
        run(1'b0, 4'b0001, 4'b0000, 3, 4'b0001, 4'b0000, "single0");
        run(1'b0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, "idle");
        // Full contention from a fresh reset: four cycles each, then wrap.
        run(1'b1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, "reset2");
        run(1'b0, 4'b1111, 4'b0000, 4, 4'b0001, 4'b0000, "rr_g0");
        run(1'b0, 4'b1111, 4'b0000, 4, 4'b0010, 4'b0000, "rr_g1");
        run(1'b0, 4'b1111, 4'b0000, 4, 4'b0100, 4'b0000, "rr_g2");
        run(1'b0, 4'b1111, 4'b0000, 4, 4'b1000, 4'b0000, "rr_g3");
        run(1'b0, 4'b1111, 4'b0000, 4, 4'b0001, 4'b0000, "rr_wrap");
        // Lone requester never expires.
        run(1'b0, 4'b0100, 4'b0000, 10, 4'b0100, 4'b0000, "lone2");
        // Holder drop: grant 1 (search starts at 2), then 1001 picks 3, then 0 via wrap.
        run(1'b0, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, "set_g1");
        run(1'b0, 4'b1001, 4'b0000, 2, 4'b1000, 4'b0000, "drop_to3");
        run(1'b0, 4'b0001, 4'b0000, 2, 4'b0001, 4'b0000, "drop_wrap0");
        // Reset in the middle of a grant, then restart from index 0.
        run(1'b0, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, "set_g2");
        run(1'b1, 4'b1111, 4'b0000, 1, 4'b0000, 4'b0000, "rst_mid");
        run(1'b0, 4'b1111, 4'b0000, 1, 4'b0001, 4'b0000, "post_rst");
        // Unlimited hold on dut_b under contention, then holder drop.
        run(1'b0, 4'b0000, 4'b0011, 22, 4'b0000, 4'b0001, "nolimit");
        run(1'b0, 4'b0000, 4'b0010, 2, 4'b0000, 4'b0010, "nolimit_drop");
        // Back-to-back grants to different requesters on dut_a.
        run(1'b0, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, "b2b_2");
        run(1'b0, 4'b1000, 4'b0000, 1, 4'b1000, 4'b0000, "b2b_3");
        run(1'b0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, "final_idle");

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rr_arbiter_n

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised N-way round-robin arbiter. It is the successor to the team's 2-requester grant FSM.
- It generalises the fixed "G0 first, then G1" fairness to N requesters, using a rotating priority pointer.
- A grant is held while its requester keeps requesting, up to a bounded number of cycles.
- Sits between N request sources and a single shared resource. Grants are registered (Moore-style).

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 4, maximum consecutive grant cycles for one requester while others are pending. 0 = unlimited hold.
- IDW, $clog2(N), width of grant_id. Derived; not to be overridden.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- grant  output  N  registered one-hot (or zero) grant vector.
- grant_id  output  IDW  index of the granted requester. 0 when grant_valid=0.
- grant_valid  output  1  high when any grant bit is set (OR of grant).

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset is dominant over req. On reset:
  - grant=0, grant_id=0, grant_valid=0.
  - Priority pointer ptr=0, hold counter cnt=0.
- Latency: req sampled at edge t drives grant after edge t (visible in cycle t+1). No combinational path from req to grant.
- State:
  - Current grant g (valid or none).
  - ptr, in 0..N-1: the index where the next search starts.
  - cnt: cycles granted to g so far minus 1. Width is enough for MAX_HOLD-1, and it saturates.
- Next-state rule, evaluated every cycle when reset=0:
  - KEEP: g valid, req[g]=1, and either MAX_HOLD=0, cnt < MAX_HOLD-1, or no other req bit set.
    - Grant unchanged; cnt increments, saturating; ptr unchanged.
  - ARBITRATE: otherwise.
    - Search indices ptr, ptr+1, ..., ptr+N-1 (mod N) and pick the first i with req[i]=1.
    - Grant i, set cnt=0, set ptr=(i+1) mod N.
    - If req=0: grant none, cnt=0, ptr unchanged.
- Consequence: under contention a requester holds the grant for exactly MAX_HOLD cycles. Because ptr already points past the expiring holder, it is searched last.
- Re-grant after expiry: if the expiring holder is the only requester, KEEP applies and there is no gap. Expiry only matters under contention.
- Holder drops req: the grant moves in the next cycle. There are no idle bubbles when another request is pending.
- Wrap-around: ptr=N-1 with the grant to N-1 sets ptr to 0.
- Back-to-back grants to different requesters: allowed on consecutive cycles.
- Reset mid-grant: the grant drops in the next cycle and arbitration restarts from index 0.
- Invariants (assertion targets):
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - When grant_valid=1, grant[grant_id]=1.
  - A grant bit is never set for a requester whose req was 0 at the preceding edge.

Test Plan:
- N=4, MAX_HOLD=4; reset, then req=0001 for 3 cycles -> grant=0001 starting one cycle after the req, grant_id=0, grant_valid=1. Then req=0 -> grant=0000 next cycle.
- req=1111 held from idle after reset -> grant 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 x4 (wrap). grant_id tracks 0, 1, 2, 3, 0.
- Single requester req=0100 for 10 cycles -> grant=0100 for all 10 cycles (no expiry without contention).
- Holder drop: grant=0010 (ptr=2), req changes to 1001 -> next grant=1000 (index 2 is not requesting, 3 is). Then req=0001 after expiry or drop -> grant=0001 (wrap).
- Reset mid-operation: reset=1 for one edge while grant=0100 and req=1111 -> grant=0000 next cycle. After reset release with req=1111 -> grant=0001.
- MAX_HOLD=0 build, req=0011 -> grant=0001 indefinitely (20+ cycles). Then req=0010 -> grant=0010 next cycle.
